// File: rtl/cpu_ctrl_pkg.sv
// Shared control encodings for the next-PC stage: decoder branch/jump selects,
// reset PC default and sequencer FSM states.
package cpu_ctrl_pkg;

  localparam int unsigned AW = 32;

  localparam logic [AW-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [2:0] BJ_BEQ   = 3'b000;
  localparam logic [2:0] BJ_BLTZ  = 3'b001;
  localparam logic [2:0] BJ_BALN  = 3'b010;
  localparam logic [2:0] BJ_JMSUB = 3'b100;
  localparam logic [2:0] BJ_JRS   = 3'b101;
  localparam logic [2:0] BJ_SEQ   = 3'b111;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_WAIT = 2'b10
  } seq_state_t;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational target generation for the next-PC stage: sequential, PC-relative
// branch, pseudo-direct jump and word-aligned memory-indirect targets.
module branch_target_calc
  import cpu_ctrl_pkg::*;
(
  input  logic [AW-1:0] pc,
  input  logic [31:0]   branch_off,
  input  logic [25:0]   jump_idx,
  input  logic [31:0]   mem_rdata,
  output logic [AW-1:0] pc_plus4,
  output logic [AW-1:0] br_target,
  output logic [AW-1:0] jmp_target,
  output logic [AW-1:0] ind_target
);

  // All additions wrap at 32 bits; overflow is intentionally not detected.
  assign pc_plus4   = pc + 32'd4;
  assign br_target  = pc_plus4 + (branch_off << 2);
  assign jmp_target = {pc_plus4[31:28], jump_idx, 2'b00};
  assign ind_target = mem_rdata & ~32'd3;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC stage: PC register, {Z,N} status flags and BOOT/RUN/WAIT sequencing FSM.
// Optional branch statistics counters when PC_BRANCH_STATS_EN is defined.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_BOOT | one fetch-settle cycle after reset, stall high, pc held
// ST_RUN  | normal operation, pc advances every cycle
// ST_WAIT | memory-indirect jump pending, stall until mem_ready
module pc_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  branch_jump,
  input  logic        stswrite,
  input  logic        alu_zero,
  input  logic        alu_neg,
  input  logic [31:0] branch_off,
  input  logic [25:0] jump_idx,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
`ifdef PC_BRANCH_STATS_EN
  output logic [31:0] br_taken_cnt,
  output logic [31:0] br_total_cnt,
`endif
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        stall,
  output logic        taken,
  output logic        status_z,
  output logic        status_n,
  output logic        misalign
);

  seq_state_t state, next_state;
  logic [AW-1:0] pc_plus4, br_target, jmp_target, ind_target, pc_next;
  logic advance, ind_taken;

  branch_target_calc u_calc (
    .pc         (pc),
    .branch_off (branch_off),
    .jump_idx   (jump_idx),
    .mem_rdata  (mem_rdata),
    .pc_plus4   (pc_plus4),
    .br_target  (br_target),
    .jmp_target (jmp_target),
    .ind_target (ind_target)
  );

  assign link_addr = pc_plus4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_BOOT;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    pc_next    = pc;
    stall      = 1'b0;
    taken      = 1'b0;
    advance    = 1'b0;
    ind_taken  = 1'b0;
    case (state)
      ST_BOOT: begin
        stall      = 1'b1;
        next_state = ST_RUN;
      end
      ST_RUN: begin
        advance = 1'b1;
        pc_next = pc_plus4;
        case (branch_jump)
          BJ_BEQ: begin
            taken = alu_zero;
            if (alu_zero) pc_next = br_target;
          end
          BJ_BLTZ: begin
            taken = alu_neg;
            if (alu_neg) pc_next = br_target;
          end
          BJ_BALN: begin
            // Registered flag from an earlier instruction; no same-cycle bypass.
            taken = status_n;
            if (status_n) pc_next = jmp_target;
          end
          BJ_JMSUB, BJ_JRS: begin
            if (mem_ready) begin
              taken     = 1'b1;
              ind_taken = 1'b1;
              pc_next   = ind_target;
            end else begin
              stall      = 1'b1;
              advance    = 1'b0;
              pc_next    = pc;
              next_state = ST_WAIT;
            end
          end
          default: ;
        endcase
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (mem_ready) begin
          stall      = 1'b0;
          taken      = 1'b1;
          ind_taken  = 1'b1;
          advance    = 1'b1;
          pc_next    = ind_target;
          next_state = ST_RUN;
        end
      end
      default: next_state = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      status_z <= 1'b0;
      status_n <= 1'b0;
      misalign <= 1'b0;
    end else begin
      pc <= pc_next;
      // The WAIT completion cycle moves pc but belongs to an already-stalled instruction.
      if (advance && state == ST_RUN && stswrite) begin
        status_z <= alu_zero;
        status_n <= alu_neg;
      end
      if (ind_taken && mem_rdata[1:0] != 2'b00) misalign <= 1'b1;
    end
  end

`ifdef PC_BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_taken_cnt <= '0;
      br_total_cnt <= '0;
    end else if (advance) begin
      if (branch_jump != BJ_SEQ) br_total_cnt <= br_total_cnt + 32'd1;
      if (taken)                 br_taken_cnt <= br_taken_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with an expected-PC scoreboard.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  branch_jump;
  logic        stswrite, alu_zero, alu_neg, mem_ready;
  logic [31:0] branch_off, mem_rdata;
  logic [25:0] jump_idx;
  logic [31:0] pc, link_addr;
  logic        stall, taken, status_z, status_n, misalign;
`ifdef PC_BRANCH_STATS_EN
  logic [31:0] br_taken_cnt, br_total_cnt;
  int          m_taken, m_total;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  pc_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .branch_jump (branch_jump),
    .stswrite    (stswrite),
    .alu_zero    (alu_zero),
    .alu_neg     (alu_neg),
    .branch_off  (branch_off),
    .jump_idx    (jump_idx),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
`ifdef PC_BRANCH_STATS_EN
    .br_taken_cnt(br_taken_cnt),
    .br_total_cnt(br_total_cnt),
`endif
    .pc          (pc),
    .link_addr   (link_addr),
    .stall       (stall),
    .taken       (taken),
    .status_z    (status_z),
    .status_n    (status_n),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of decoder inputs, check stall/taken before the edge,
  // then compare the new pc against the scoreboard after the edge.
  task automatic step(input string tag, input logic [2:0] bj, input logic sw,
                      input logic z, input logic n, input logic [31:0] off,
                      input logic [25:0] idx, input logic [31:0] rd, input logic rdy,
                      input logic e_stall, input logic e_taken, input logic [31:0] e_pc);
    logic [31:0] exp_pc;
    branch_jump = bj; stswrite = sw; alu_zero = z; alu_neg = n;
    branch_off = off; jump_idx = idx; mem_rdata = rd; mem_ready = rdy;
    exp_q.push_back(e_pc);
`ifdef PC_BRANCH_STATS_EN
    if (!e_stall) begin
      if (bj != 3'b111) m_total++;
      if (e_taken) m_taken++;
    end
`endif
    #1;
    chk({tag, "_stall"}, {31'd0, stall}, {31'd0, e_stall});
    chk({tag, "_taken"}, {31'd0, taken}, {31'd0, e_taken});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_sb: observed empty expected entry", tag);
    end else begin
      exp_pc = exp_q.pop_front();
      chk({tag, "_pc"}, pc, exp_pc);
    end
  endtask

  task automatic seq(input string tag, input logic [31:0] e_pc);
    step(tag, 3'b111, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0, 1'b0, e_pc);
  endtask

  task automatic jrs(input string tag, input logic [31:0] tgt);
    step(tag, 3'b101, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0, tgt, 1'b1, 1'b0, 1'b1, tgt & ~32'd3);
  endtask

  initial begin
    rst_n = 1'b0;
    branch_jump = 3'b111; stswrite = 1'b0; alu_zero = 1'b0; alu_neg = 1'b0;
    branch_off = '0; jump_idx = '0; mem_rdata = '0; mem_ready = 1'b0;
`ifdef PC_BRANCH_STATS_EN
    m_taken = 0; m_total = 0;
`endif
    #2;
    chk("rst_pc", pc, 32'h0);
    chk("rst_stall", {31'd0, stall}, 32'd1);
    chk("rst_taken", {31'd0, taken}, 32'd0);
    chk("rst_flags", {29'd0, status_z, status_n, misalign}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    step("boot", 3'b111, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h0);
    seq("seq1", 32'h4);
    seq("seq2", 32'h8);
    seq("seq3", 32'hC);

    jrs("jrs_100", 32'h100);
    chk("link_100", link_addr, 32'h104);
    step("beq_t", 3'b000, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 26'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'hFC);
    chk("misalign_clr", {31'd0, misalign}, 32'd0);
    jrs("jrs_100b", 32'h100);
    step("beq_nt", 3'b000, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE, 26'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'h104);
    step("bltz_t", 3'b001, 1'b0, 1'b0, 1'b1, 32'd4, 26'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h118);
    step("bltz_nt", 3'b001, 1'b0, 1'b1, 1'b0, 32'd4, 26'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'h11C);

    step("sts_n1", 3'b111, 1'b1, 1'b0, 1'b1, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'h120);
    chk("flags_n1", {30'd0, status_z, status_n}, 32'b01);
    jrs("jrs_1000", 32'h1000);
    step("baln_t", 3'b010, 1'b0, 1'b0, 1'b0, 32'd0, 26'h40, 32'd0, 1'b0, 1'b0, 1'b1, 32'h100);
    step("sts_z1", 3'b111, 1'b1, 1'b1, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'h104);
    chk("flags_z1", {30'd0, status_z, status_n}, 32'b10);
    jrs("jrs_1000b", 32'h1000);
    // alu_neg high must not influence baln
    step("baln_nt", 3'b010, 1'b0, 1'b0, 1'b1, 32'd0, 26'h40, 32'd0, 1'b0, 1'b0, 1'b0, 32'h1004);

    for (int i = 0; i < 3; i++)
      step("wait", 3'b101, 1'b1, 1'b0, 1'b1, 32'd0, 26'd0, 32'h2002, 1'b0, 1'b1, 1'b0, 32'h1004);
    step("wait_done", 3'b101, 1'b1, 1'b0, 1'b1, 32'd0, 26'd0, 32'h2002, 1'b1, 1'b0, 1'b1, 32'h2000);
    chk("misalign_set", {31'd0, misalign}, 32'd1);
    chk("flags_hold", {30'd0, status_z, status_n}, 32'b10);

`ifdef PC_BRANCH_STATS_EN
    chk("br_total", br_total_cnt, m_total);
    chk("br_taken", br_taken_cnt, m_taken);
`endif

    step("jm_wait", 3'b100, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0, 32'h3000, 1'b0, 1'b1, 1'b0, 32'h2000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_flags", {29'd0, status_z, status_n, misalign}, 32'd0);
    chk("midrst_stall", {31'd0, stall}, 32'd1);
`ifdef PC_BRANCH_STATS_EN
    m_taken = 0; m_total = 0;
    chk("midrst_cnt", br_total_cnt | br_taken_cnt, 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("boot2", 3'b111, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h0);

    jrs("jrs_top", 32'hFFFF_FFFC);
    chk("link_wrap", link_addr, 32'h0);
    seq("wrap", 32'h0);
    step("bj011", 3'b011, 1'b0, 1'b1, 1'b1, 32'd8, 26'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'h4);
    chk("misalign_final", {31'd0, misalign}, 32'd0);

`ifdef PC_BRANCH_STATS_EN
    chk("br_total2", br_total_cnt, m_total);
    chk("br_taken2", br_taken_cnt, m_taken);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
